// File: rtl/regfile_wr_arb_if.sv
// Register-file write arbiter bundle.
// Groups the two requester handshakes, the clear request and the registered
// regfile write port plus status outputs.
//   master : requester/control side (drives requests and clr_req)
//   slave  : arbiter side (drives ready, rf_* write port, init_done, conflict_cnt)
interface regfile_wr_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              clr_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;
    logic [7:0]        conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_req,
        input  req0_ready, req1_ready,
        input  rf_we, rf_rd, rf_wdata, init_done, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_req,
        output req0_ready, req1_ready,
        output rf_we, rf_rd, rf_wdata, init_done, conflict_cnt
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Two-requester round-robin write arbiter in front of a register file.
// After reset (or a clr_req pulse) it walks every register writing zero, then
// grants one write per cycle, alternating priority between requesters when
// both want the port. The regfile write port is registered (1-cycle latency).
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wr_arb_if.slave (requests, clr_req, rf_* port, status)
module regfile_wr_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    regfile_wr_arb_if.slave  bus
);

    typedef enum logic {
        StClear,
        StRun
    } state_e;

    localparam logic [ADDR_W-1:0] LastReg = '1;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_prio;        // requester that wins when both are valid
    logic                r_rf_we;
    logic [ADDR_W-1:0]   r_rf_rd;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_init_done;
    logic [7:0]          r_conflict_cnt;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_both;

    assign w_both = bus.req0_valid & bus.req1_valid;

    // Next state and combinational grant; ready already implies valid.
    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        unique case (r_state)
            StClear: begin
                if (r_clr_cnt == LastReg) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (bus.clr_req) begin
                    w_state_next = StClear;
                end else begin
                    w_ready0 = bus.req0_valid & (~bus.req1_valid | ~r_prio);
                    w_ready1 = bus.req1_valid & (~bus.req0_valid | r_prio);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StClear;
            r_clr_cnt      <= '0;
            r_prio         <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_rd        <= '0;
            r_rf_wdata     <= '0;
            r_init_done    <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_init_done <= (w_state_next == StRun);
            unique case (r_state)
                StClear: begin
                    r_rf_we    <= 1'b1;
                    r_rf_rd    <= r_clr_cnt;
                    r_rf_wdata <= '0;
                    // Natural wrap returns the counter to 0 as CLEAR is left.
                    r_clr_cnt  <= r_clr_cnt + 1'b1;
                end
                StRun: begin
                    r_clr_cnt <= '0;
                    if (w_ready0) begin
                        r_rf_we    <= 1'b1;
                        r_rf_rd    <= bus.req0_addr;
                        r_rf_wdata <= bus.req0_data;
                        r_prio     <= 1'b1;
                    end else if (w_ready1) begin
                        r_rf_we    <= 1'b1;
                        r_rf_rd    <= bus.req1_addr;
                        r_rf_wdata <= bus.req1_data;
                        r_prio     <= 1'b0;
                    end else begin
                        r_rf_we <= 1'b0;
                    end
                    if (!bus.clr_req && w_both && (r_conflict_cnt != 8'hFF)) begin
                        r_conflict_cnt <= r_conflict_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready   = w_ready0;
    assign bus.req1_ready   = w_ready1;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_rd        = r_rf_rd;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.init_done    = r_init_done;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: directed vector table, hand-written
// clear/reset sequences and a randomized phase checked against a reference model.
module tb_regfile_wr_arb;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: index of the next register to clear (NREG = running),
    // priority owner, conflict count, expected write port, and register image.
    int                m_next_clear;
    int                m_prio;
    int                m_conf;
    logic              m_we;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wd;
    logic              m_init;
    logic [DATA_W-1:0] m_mem [NREG];
    logic [DATA_W-1:0] d_mem [NREG];
    logic              last_r0;
    logic              last_r1;

    typedef struct {
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic              clr;
        logic              r0;
        logic              r1;
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
        logic              init;
        logic [7:0]        conf;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_next_clear = 0;
        m_prio       = 0;
        m_conf       = 0;
        m_we         = 1'b0;
        m_rd         = '0;
        m_wd         = '0;
        m_init       = 1'b0;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    endtask

    task automatic set_in(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                          input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                          input logic clr);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        bus.clr_req    = clr;
    endtask

    // One clock: check grants mid-cycle, advance the model, check the write port after the edge.
    task automatic cycle();
        bit run, e0, e1;
        run = (m_next_clear == NREG);
        e0  = 1'b0;
        e1  = 1'b0;
        if (run && !bus.clr_req) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e0 = (m_prio == 0);
                e1 = (m_prio == 1);
            end else begin
                e0 = bus.req0_valid;
                e1 = bus.req1_valid;
            end
        end
        @(negedge clk);
        last_r0 = bus.req0_ready;
        last_r1 = bus.req1_ready;
        check("req0_ready", last_r0, e0);
        check("req1_ready", last_r1, e1);
        if (!run) begin
            m_we = 1'b1;
            m_rd = m_next_clear[ADDR_W-1:0];
            m_wd = '0;
            m_next_clear++;
        end else if (bus.clr_req) begin
            m_we         = 1'b0;
            m_next_clear = 0;
            for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        end else begin
            if (e0) begin
                m_we = 1'b1; m_rd = bus.req0_addr; m_wd = bus.req0_data;
                m_mem[bus.req0_addr] = bus.req0_data;
                m_prio = 1;
            end else if (e1) begin
                m_we = 1'b1; m_rd = bus.req1_addr; m_wd = bus.req1_data;
                m_mem[bus.req1_addr] = bus.req1_data;
                m_prio = 0;
            end else begin
                m_we = 1'b0;
            end
            if (bus.req0_valid && bus.req1_valid && m_conf < 255) m_conf++;
        end
        m_init = (m_next_clear == NREG);
        @(posedge clk);
        #1;
        check("rf_we", bus.rf_we, m_we);
        check("rf_rd", bus.rf_rd, m_rd);
        check("rf_wdata", bus.rf_wdata, m_wd);
        check("init_done", bus.init_done, m_init);
        check("conflict_cnt", bus.conflict_cnt, m_conf);
        if (bus.rf_we) d_mem[bus.rf_rd] = bus.rf_wdata;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rf_we"}, bus.rf_we, 1'b0);
        check({tag, ".rf_rd"}, bus.rf_rd, 0);
        check({tag, ".rf_wdata"}, bus.rf_wdata, 0);
        check({tag, ".init_done"}, bus.init_done, 1'b0);
        check({tag, ".conflict_cnt"}, bus.conflict_cnt, 0);
        check({tag, ".req0_ready"}, bus.req0_ready, 1'b0);
        check({tag, ".req1_ready"}, bus.req1_ready, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v0 a0 d0            v1 a1 d1       clr r0 r1 we rd wd            init conf
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,       0,  1, 0, 1, 5, 32'hDEADBEEF, 1,   0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0,       0,  0, 0, 0, 5, 32'hDEADBEEF, 1,   0};
        tbl[2]  = '{0, 0, 0,            1, 2, 32'h202, 0,  0, 1, 1, 2, 32'h202,      1,   0};
        tbl[3]  = '{1, 3, 32'h33,       1, 7, 32'h77,  0,  1, 0, 1, 3, 32'h33,       1,   1};
        tbl[4]  = '{1, 3, 32'h33,       1, 7, 32'h77,  0,  0, 1, 1, 7, 32'h77,       1,   2};
        tbl[5]  = '{1, 3, 32'h33,       1, 7, 32'h77,  0,  1, 0, 1, 3, 32'h33,       1,   3};
        tbl[6]  = '{1, 3, 32'h33,       1, 7, 32'h77,  0,  0, 1, 1, 7, 32'h77,       1,   4};
        tbl[7]  = '{1, 9, 32'h11,       1, 9, 32'h22,  0,  1, 0, 1, 9, 32'h11,       1,   5};
        tbl[8]  = '{0, 0, 0,            1, 9, 32'h22,  0,  0, 1, 1, 9, 32'h22,       1,   5};
        tbl[9]  = '{1, 9, 32'h11,       1, 9, 32'h22,  1,  0, 0, 0, 9, 32'h22,       0,   5};
        tbl[10] = '{1, 1, 32'h1,        1, 2, 32'h2,   0,  0, 0, 1, 0, 0,            0,   5};

        for (int i = 0; i < NREG; i++) d_mem[i] = '0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        last_r0 = 1'b0;
        last_r1 = 1'b0;

        // Power-on reset.
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_values("por");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Initial clear sweep: rf_rd 0..31, init_done with the last one.
        for (int k = 0; k < NREG; k++) begin
            cycle();
            check("init.rf_we", bus.rf_we, 1'b1);
            check("init.rf_rd", bus.rf_rd, k);
            check("init.rf_wdata", bus.rf_wdata, 0);
            check("init.init_done", bus.init_done, (k == NREG - 1));
        end

        // Directed vectors: single writes, round-robin contention, same-address order, clr_req.
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].clr);
            cycle();
            check($sformatf("vec%0d.req0_ready", i), last_r0, tbl[i].r0);
            check($sformatf("vec%0d.req1_ready", i), last_r1, tbl[i].r1);
            check($sformatf("vec%0d.rf_we", i), bus.rf_we, tbl[i].we);
            check($sformatf("vec%0d.rf_rd", i), bus.rf_rd, tbl[i].rd);
            check($sformatf("vec%0d.rf_wdata", i), bus.rf_wdata, tbl[i].wd);
            check($sformatf("vec%0d.init_done", i), bus.init_done, tbl[i].init);
            check($sformatf("vec%0d.conflict_cnt", i), bus.conflict_cnt, tbl[i].conf);
        end

        // Rest of the clear sweep with req0 held; it is accepted once init_done rises.
        set_in(1, 1, 32'h1, 0, 0, 0, 0);
        for (int k = 1; k < NREG; k++) begin
            cycle();
            check("reclr.req0_ready", last_r0, 1'b0);
            check("reclr.rf_rd", bus.rf_rd, k);
            check("reclr.init_done", bus.init_done, (k == NREG - 1));
        end
        cycle();
        check("reclr.accept", last_r0, 1'b1);
        check("reclr.rf_we", bus.rf_we, 1'b1);
        check("reclr.rf_rd", bus.rf_rd, 1);
        check("reclr.rf_wdata", bus.rf_wdata, 32'h1);

        // Reset in the middle of a clear sweep aborts at once and restarts from 0.
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (10) cycle();
        check("midclr.rf_rd", bus.rf_rd, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check("restart.rf_we", bus.rf_we, 1'b1);
        check("restart.rf_rd", bus.rf_rd, 0);
        repeat (NREG - 1) cycle();
        check("restart.init_done", bus.init_done, 1'b1);

        // Randomized traffic: requesters hold a request until it is granted.
        for (int n = 0; n < 500; n++) begin
            if (!bus.req0_valid || last_r0) begin
                bus.req0_valid = ($urandom_range(0, 9) < 6);
                bus.req0_addr  = ADDR_W'($urandom);
                bus.req0_data  = $urandom;
            end
            if (!bus.req1_valid || last_r1) begin
                bus.req1_valid = ($urandom_range(0, 9) < 6);
                bus.req1_addr  = ADDR_W'($urandom);
                bus.req1_data  = $urandom;
            end
            bus.clr_req = ($urandom_range(0, 63) == 0);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40 && m_next_clear != NREG; i++) cycle();
        cycle();
        check("rand.init_done", bus.init_done, 1'b1);
        for (int i = 0; i < NREG; i++) check($sformatf("regfile[%0d]", i), d_mem[i], m_mem[i]);

        // Long contention saturates the conflict counter.
        set_in(1, 4, $urandom, 1, 6, $urandom, 0);
        repeat (300) cycle();
        check("sat.conflict_cnt", bus.conflict_cnt, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  write request from requester 0 (ALU writeback) / 1 (load unit).
REQ-006 SHALL have ports req0_addr / req1_addr  input  ADDR_W  destination register.
REQ-007 SHALL have ports req0_data / req1_data  input  DATA_W  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-009 SHALL have port clr_req  input  1  single-cycle pulse, re-zero the whole register file.
REQ-010 SHALL have ports rf_we  output  1, rf_rd  output  ADDR_W, rf_wdata  output  DATA_W  registered write port driving the regfile we/rd/indata.
REQ-011 SHALL have port init_done  output  1  high when in RUN.
REQ-012 SHALL have port conflict_cnt  output  8  saturating count of arbitration-loss cycles.

Function
REQ-013 SHALL implement FSM states CLEAR and RUN; CLEAR -> RUN on the cycle clr_cnt = 2^ADDR_W-1; RUN -> CLEAR on clr_req=1.
REQ-014 In CLEAR, each cycle SHALL register rf_we<=1, rf_rd<=clr_cnt, rf_wdata<=0, then clr_cnt<=clr_cnt+1 (wraps to 0 on leaving CLEAR).
REQ-015 In CLEAR, req0_ready and req1_ready SHALL be 0.
REQ-016 In RUN with clr_req=1, both ready SHALL be 0; next state CLEAR with clr_cnt=0.
REQ-017 In RUN with clr_req=0, ready SHALL be combinational: only reqN_valid -> reqN_ready=1; both valid -> ready only to the requester selected by prio; none valid -> both 0.
REQ-018 At most one ready SHALL be high in any cycle.
REQ-019 On accept (valid&ready) of requester N, the next cycle SHALL present rf_we=1, rf_rd=reqN_addr, rf_wdata=reqN_data (latency 1 cycle); otherwise rf_we<=0, rf_rd/rf_wdata hold.
REQ-020 prio SHALL update only on an accept, to the index of the non-granted requester (round-robin); unchanged otherwise.
REQ-021 Both valid with same address: SHALL serialise, prio winner written first, loser next cycle (last write wins in regfile).
REQ-022 Requesters hold valid/addr/data stable until accepted; the block SHALL NOT latch unaccepted requests.
REQ-023 conflict_cnt SHALL increment by 1 each RUN cycle with clr_req=0 and both valid; saturate at 255.
REQ-024 init_done SHALL equal (state==RUN), registered; it rises in the same cycle rf_rd=2^ADDR_W-1 clear write is presented.
REQ-025 A write accepted in the cycle init_done first rises SHALL appear on rf_* the cycle after the last clear write.

Reset
REQ-026 While rst_n=0: state=CLEAR, clr_cnt=0, prio=0, rf_we=0, rf_rd=0, rf_wdata=0, init_done=0, conflict_cnt=0, both ready=0.
REQ-027 Reset asserted mid-CLEAR or mid-RUN SHALL abort immediately; clear sequence restarts from register 0 after release.
REQ-028 clr_req SHALL NOT clear conflict_cnt or prio.

Verification
REQ-029 Release reset -> rf_we=1 for 32 consecutive cycles with rf_rd=0..31, rf_wdata=0; init_done=1 from the cycle rf_rd=31.
REQ-030 RUN, req0 valid addr=5 data=0xDEADBEEF alone -> req0_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
REQ-031 RUN, both valid for 4 cycles (addr 3/7), prio=0 -> grants 0,1,0,1; rf_rd 3,7,3,7; conflict_cnt=4.
REQ-032 Both valid addr=9, data0=0x11, data1=0x22, prio=0 -> rf writes 0x11 then 0x22 to reg 9.
REQ-033 clr_req pulse in RUN with req0 valid -> req0_ready=0 that cycle; next 32 cycles clear writes, init_done=0 until rf_rd=31, then req0 accepted.
REQ-034 rst_n low at clear cycle 10 -> all outputs to reset values; after release clear restarts at rf_rd=0; conflict_cnt saturates at 255 under 300 contended cycles.
